// File: rtl/gpio_display_scanner.sv
// Memory-mapped scanner for a shared 4-digit 7-segment display.
// Four digit registers plus CTRL sit at BASE_ADDR..BASE_ADDR+4. A prescaled FSM
// walks the digits, with optional all-off slots between them to suppress ghosting.
`timescale 1ns/1ps
module gpio_display_scanner #(
   parameter int unsigned BASE_ADDR    = 4096,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 4,
   parameter int unsigned ADDR_W       = 32
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              MEM_ENA,
   input  logic              MEM_WE,
   input  logic [ADDR_W-1:0] DADDR,
   input  logic [7:0]        DIN,
   output logic [7:0]        DOUT,
   output logic [6:0]        SEG,
   output logic              DP,
   output logic [3:0]        AN,
   output logic [1:0]        DIGIT_IDX,
   output logic              TICK
);

   // One counter serves both the SHOW and BLANK phases, so size it for the longer one.
   localparam int unsigned CntMax    = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
   localparam int unsigned CntW      = (CntMax > 1) ? $clog2(CntMax) : 1;
   localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);
   localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam bit              BlankOk   = (BLANK_CYCLES > 0);

   typedef enum logic [1:0] {StOff, StShow, StBlank} state_e;

   logic [ADDR_W-1:0] offset;
   logic [2:0]        reg_sel;
   logic              hit, wr_en, rd_en;
   logic [7:0]        digit_q [4];
   logic [7:0]        ctrl_q;
   logic              en, blank_en;
   logic [3:0]        mask;

   state_e            state_q;
   logic [1:0]        idx_q;
   logic [CntW-1:0]   cnt_q;
   logic [3:0]        an_q;
   logic [6:0]        seg_q;
   logic              dp_q;

   // Offset arithmetic wraps below BASE_ADDR, so a single unsigned compare covers the window.
   assign offset  = DADDR - ADDR_W'(BASE_ADDR);
   assign hit     = (offset < ADDR_W'(5));
   assign reg_sel = offset[2:0];
   assign wr_en   = MEM_ENA & MEM_WE & hit;
   assign rd_en   = MEM_ENA & ~MEM_WE & hit;

   assign en       = ctrl_q[0];
   assign blank_en = ctrl_q[1];
   assign mask     = ctrl_q[7:4];

   // Bus writes into the digit and control registers; CTRL[3:2] are held at zero.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < 4; i++) digit_q[i] <= 8'hFF;
         ctrl_q <= 8'h00;
      end else if (wr_en) begin
         if (reg_sel == 3'd4) ctrl_q <= {DIN[7:4], 2'b00, DIN[1:0]};
         else                 digit_q[reg_sel[1:0]] <= DIN;
      end
   end

   // Combinational read-back; zero when not a read hit.
   always_comb begin
      DOUT = 8'h00;
      if (rd_en) begin
         if (reg_sel == 3'd4) DOUT = ctrl_q;
         else                 DOUT = digit_q[reg_sel[1:0]];
      end
   end

   // Scan FSM plus display output registers, which trail state/idx by one cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StOff;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         an_q    <= 4'hF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
      end else begin
         if (state_q == StShow && mask[idx_q]) begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= digit_q[idx_q][6:0];
            dp_q  <= digit_q[idx_q][7];
         end else begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
         end

         // Disable wins over any in-flight tick.
         if (!en) begin
            state_q <= StOff;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               StOff: begin
                  state_q <= StShow;
                  idx_q   <= 2'd0;
                  cnt_q   <= '0;
               end
               StShow: begin
                  if (cnt_q == ShowLast) begin
                     cnt_q <= '0;
                     idx_q <= idx_q + 2'd1;
                     if (blank_en && BlankOk) state_q <= StBlank;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StBlank: begin
                  if (cnt_q == BlankLast) begin
                     cnt_q   <= '0;
                     state_q <= StShow;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= StOff;
                  idx_q   <= 2'd0;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign AN        = an_q;
   assign SEG       = seg_q;
   assign DP        = dp_q;
   assign DIGIT_IDX = idx_q;
   assign TICK      = (state_q == StShow) && (cnt_q == ShowLast);

endmodule
